// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer.
// Borrows the shared add/sub unit through alu_* while busy; N steps plus one done cycle.
module muldiv_sequencer #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_s,
  input  logic [N-1:0] alu_sum,
  input  logic         alu_carry,
  output logic [N-1:0] result_hi,
  output logic [N-1:0] result_lo,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [N-1:0]  m_q, m_n;
  logic [N-1:0]  h_q, h_n;
  logic [N-1:0]  l_q, l_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          op_q, op_n;
  logic          dz_q, dz_n;
  logic          busy_n, done_n;
  logic [N-1:0]  rs;
  logic          take;

  // Partial remainder shifted left by one, pulling in the next dividend bit
  assign rs = {h_q[N-2:0], l_q[N-1]};

  assign result_hi = h_q;
  assign result_lo = l_q;
  assign div_zero  = dz_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m_q   <= '0;
      h_q   <= '0;
      l_q   <= '0;
      cnt_q <= '0;
      op_q  <= 1'b0;
      dz_q  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      m_q   <= m_n;
      h_q   <= h_n;
      l_q   <= l_n;
      cnt_q <= cnt_n;
      op_q  <= op_n;
      dz_q  <= dz_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state, datapath step and ALU drive
  always_comb begin
    state_n = state;
    m_n     = m_q;
    h_n     = h_q;
    l_n     = l_q;
    cnt_n   = cnt_q;
    op_n    = op_q;
    dz_n    = dz_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_s   = 1'b0;
    take    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          op_n    = op;
          h_n     = '0;
          cnt_n   = '0;
          dz_n    = op & (b == '0);
          m_n     = op ? b : a;
          l_n     = op ? a : b;
        end
      end
      RUN: begin
        cnt_n = cnt_q + CW'(1);
        if (op_q) begin
          alu_a = rs;
          alu_b = m_q;
          alu_s = 1'b1;
          // H[N-1] set means the shifted remainder exceeds N bits, so it always covers M
          take  = h_q[N-1] | alu_carry;
          h_n   = take ? alu_sum : rs;
          l_n   = {l_q[N-2:0], take};
        end else begin
          alu_a = h_q;
          alu_b = m_q;
          if (l_q[0]) begin
            {h_n, l_n} = {alu_carry, alu_sum, l_q[N-1:1]};
          end else begin
            {h_n, l_n} = {1'b0, h_q, l_q[N-1:1]};
          end
        end
        if (cnt_q == LAST) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer with a behavioural add/sub unit attached.
module tb_muldiv_sequencer;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [N-1:0] a, b;
  logic [N-1:0] alu_a, alu_b, alu_sum;
  logic         alu_s, alu_carry;
  logic [N-1:0] result_hi, result_lo;
  logic         busy, done, div_zero;

  typedef struct packed {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  muldiv_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_sum(alu_sum), .alu_carry(alu_carry),
    .result_hi(result_hi), .result_lo(result_lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Shared adder: subtract via two's complement, carry = no borrow
  logic [N:0] alu_t;
  always_comb begin
    if (alu_s) alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + (N+1)'(1);
    else       alu_t = {1'b0, alu_a} + {1'b0, alu_b};
    alu_sum   = alu_t[N-1:0];
    alu_carry = alu_t[N];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_hi", 32'(result_hi), 32'(e.hi));
        check("result_lo", 32'(result_lo), 32'(e.lo));
        check("div_zero",  32'(div_zero),  32'(e.dz));
      end
    end
  end

  // Issue one op; optionally spam start with other operands during RUN
  task automatic run_op(input logic o, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input bit push, input exp_t e, input bit spam);
    int cyc, bcyc;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0; bcyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
      if (done) begin
        seen  = 1;
        start = 1'b0;
      end else if (spam) begin
        start = 1'b1; op = ~o; a = 4'h2; b = 4'h3;
      end
    end
    check("done_latency", 32'(cyc), 32'(N + 1));
    check("busy_cycles",  32'(bcyc), 32'(N));
    @(negedge clk);
    check("idle_after_done", 32'({busy, done}), 32'(0));
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #12;
    check("rst_outputs", 32'({busy, done, div_zero, result_hi, result_lo}), 32'(0));
    check("rst_alu", 32'({alu_s, alu_a, alu_b}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_alu", 32'({alu_s, alu_a, alu_b}), 32'(0));

    e = '{hi: 4'h8, lo: 4'hF, dz: 1'b0}; run_op(1'b0, 4'd13, 4'd11, 1, e, 0);
    e = '{hi: 4'hE, lo: 4'h1, dz: 1'b0}; run_op(1'b0, 4'd15, 4'd15, 1, e, 0);
    e = '{hi: 4'h0, lo: 4'h0, dz: 1'b0}; run_op(1'b0, 4'd0,  4'd9,  1, e, 0);
    e = '{hi: 4'h1, lo: 4'h4, dz: 1'b0}; run_op(1'b1, 4'd13, 4'd3,  1, e, 0);
    e = '{hi: 4'h2, lo: 4'h0, dz: 1'b0}; run_op(1'b1, 4'd2,  4'd7,  1, e, 0);
    e = '{hi: 4'h9, lo: 4'hF, dz: 1'b1}; run_op(1'b1, 4'd9,  4'd0,  1, e, 0);
    e = '{hi: 4'h8, lo: 4'hF, dz: 1'b0}; run_op(1'b0, 4'd13, 4'd11, 1, e, 1);

    // Asynchronous reset between edges mid-RUN
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 4'd15; b = 4'd15;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy_done", 32'({busy, done}), 32'(0));
    check("abort_results", 32'({result_hi, result_lo, div_zero}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 2) @(negedge clk);
    check("no_done_after_abort", 32'({busy, done}), 32'(0));

    e = '{hi: 4'h2, lo: 4'hA, dz: 1'b0}; run_op(1'b0, 4'd6, 4'd7, 1, e, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller that sequences the shared add/sub arithmetic unit to perform unsigned N-bit multiply (shift-add) and divide (restoring). It sits beside the ALU in the processor: it owns the adder's operand and mode inputs while busy and takes the sum and carry back combinationally. Each operation takes exactly N iteration cycles plus one done cycle.

## Interface
- N, 4, operand width in bits; N ≥ 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide; latched with start.
- a  in  N  multiplicand or dividend; latched with start.
- b  in  N  multiplier or divisor; latched with start.
- alu_a  out  N  adder operand A.
- alu_b  out  N  adder operand B.
- alu_s  out  1  adder mode: 0 = add, 1 = subtract.
- alu_sum  in  N  adder result, combinational from alu_a/alu_b/alu_s.
- alu_carry  in  1  add: carry out. Subtract: 1 when alu_a ≥ alu_b (no borrow).
- result_hi  out  N  product upper half, or remainder.
- result_lo  out  N  product lower half, or quotient.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- div_zero  out  1  divide was started with b = 0; valid with results.

## Operation
- Registers: M (N, operand b/divisor or a/multiplicand), H (N), L (N), count (clog2(N) bits), op_r.
- States: IDLE, RUN, DONE.
- IDLE → RUN when start = 1. Latch op_r = op, H = 0, count = 0, div_zero = op & (b == 0).
  - Multiply: M = a, L = b.
  - Divide: M = b, L = a.
- RUN performs one step per cycle and increments count. After the step with count = N−1, go to DONE.
- RUN → DONE → IDLE unconditionally.
- Multiply step:
  - Drive alu_a = H, alu_b = M, alu_s = 0.
  - If L[0] = 1: {H, L} ← {alu_carry, alu_sum, L[N−1:1]} taken as the top 2N bits.
  - Otherwise: {H, L} ← {1'b0, H, L[N−1:1]} taken as the top 2N bits.
- Divide step:
  - Compute Rs = {H[N−2:0], L[N−1]}.
  - Drive alu_a = Rs, alu_b = M, alu_s = 1.
  - take = H[N−1] | alu_carry.
  - H ← take ? alu_sum : Rs.
  - L ← {L[N−2:0], take}.
- Outputs:
  - result_hi = H and result_lo = L at all times.
  - Results are valid from the DONE cycle until the next start is accepted.
- In IDLE and DONE, drive alu_a = 0, alu_b = 0, alu_s = 0.
- Divide by zero needs no special path. It yields quotient = all ones and remainder = dividend, with div_zero = 1.
- start is ignored while in RUN or DONE. op, a and b are ignored outside the start cycle.

## Timing
- Reset (asynchronous): state = IDLE. M, H, L, count, op_r and div_zero are cleared to 0. busy = 0, done = 0, and all outputs read 0.
- Reset during RUN or DONE aborts the operation. No done pulse is produced.
- start accepted at edge k: RUN occupies cycles k+1 … k+N, and done = 1 during cycle k+N+1.
- The earliest next accepted start is the edge that ends the DONE cycle+1, i.e. while in IDLE. Back-to-back issue spacing is N+2 cycles.
- busy and done are Moore outputs, registered with the state.
- The ALU path is combinational within one cycle; alu_sum and alu_carry must settle before the edge.

## Test plan
- N=4, multiply a=13, b=11 → after 5 cycles done = 1, result_hi = 0x8, result_lo = 0xF (143); busy high for exactly 4 cycles.
- Multiply a=15, b=15 → result_hi = 0xE, result_lo = 0x1 (225). Multiply a=0, b=9 → both results 0.
- Divide a=13, b=3 → result_lo = 4, result_hi = 1, div_zero = 0. Divide a=2, b=7 → quotient 0, remainder 2.
- Divide a=9, b=0 → result_lo = 0xF, result_hi = 9, div_zero = 1.
- Assert start with new operands on every RUN cycle → ignored; result equals the first operation's.
- Assert rst asynchronously mid-RUN (between edges) → busy, done and the results go to 0 immediately. A following start with a=6, b=7, op=0 gives 42 (0x2A).
